// File: rtl/nim_input_conditioner_if.sv
// nim_input_conditioner_if: channel input, trigger configuration and conditioned outputs of one front-end channel
interface nim_input_conditioner_if #(
  parameter int HIST_LEN  = 8,
  parameter int DELAY_W   = 8,
  parameter int STRETCH_W = 64,
  parameter int CNT_W     = 32
);
  logic                 din;
  logic                 invert;
  logic [HIST_LEN-1:0]  trig_pattern;
  logic [HIST_LEN-1:0]  mask;
  logic [DELAY_W-1:0]   delay;
  logic [STRETCH_W-1:0] stretch;
  logic                 cnt_clear;
  logic                 trig_out;
  logic                 dout;
  logic [CNT_W-1:0]     trig_count;
  modport master (
    output din, invert, trig_pattern, mask, delay, stretch, cnt_clear,
    input  trig_out, dout, trig_count
  );
  modport slave (
    input  din, invert, trig_pattern, mask, delay, stretch, cnt_clear,
    output trig_out, dout, trig_count
  );
endinterface

// File: rtl/nim_input_conditioner.sv
// nim_input_conditioner: sync, invert, masked pattern match, programmable delay and stretch of one input channel
module nim_input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int HIST_LEN    = 8,
  parameter int DELAY_W     = 8,
  parameter int STRETCH_W   = 64,
  parameter int CNT_W       = 32
) (
  input logic clk,
  input logic reset,
  nim_input_conditioner_if.slave io
);
  localparam int DLEN = 2**DELAY_W - 1;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [HIST_LEN-1:0]    hist_q, hist_d;
  logic                   trig_q, trig_d;
  logic [DLEN-1:0]        sr_q, sr_d;
  logic [STRETCH_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   tap;
  // the delay tap is combinational so a delay change is seen on the very next cycle
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], io.din};
    hist_d  = {hist_q[HIST_LEN-2:0], sync_q[SYNC_STAGES-1] ^ io.invert};
    trig_d  = ((hist_q ^ io.trig_pattern) & io.mask) == '0;
    sr_d    = {sr_q[DLEN-2:0], trig_q};
    tap     = (io.delay == '0) ? trig_q : sr_q[io.delay - 1'b1];
    cnt_d   = tap ? ((io.stretch == '0) ? STRETCH_W'(1) : io.stretch)
                  : ((cnt_q != '0) ? cnt_q - 1'b1 : cnt_q);
    count_d = io.cnt_clear ? '0 : ((tap && count_q != '1) ? count_q + 1'b1 : count_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      hist_q  <= '0;
      trig_q  <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      trig_q  <= trig_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end
  assign io.trig_out   = tap;
  assign io.dout       = cnt_q != '0;
  assign io.trig_count = count_q;
endmodule

// File: tb/tb_nim_input_conditioner.sv
// tb_nim_input_conditioner: directed and random checks against a cycle-indexed sample-history model
module tb_nim_input_conditioner;
  localparam int HL = 8, DW = 8, SW = 64, CW = 4, N = 16384;
  localparam int CMAX = 2**CW - 1;
  logic clk = 1'b0;
  logic reset;
  int errors = 0, checks = 0;
  nim_input_conditioner_if #(.HIST_LEN(HL), .DELAY_W(DW), .STRETCH_W(SW), .CNT_W(CW)) io ();
  nim_input_conditioner #(.SYNC_STAGES(2), .HIST_LEN(HL), .DELAY_W(DW), .STRETCH_W(SW), .CNT_W(CW))
    uut (.clk(clk), .reset(reset), .io(io));
  always #5 clk = ~clk;
  bit dv[N], iv[N], tr[N];
  int t = 0, r = 0, load_e = -1, n = 0;
  longint unsigned lw = 0;
  int mark, first_to, first_do, last_do, to_cnt, do_cnt;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t);
    end
  endtask
  function automatic bit hb0(input int k);
    bit s;
    s = (k - 2 > r) ? dv[k-2] : 1'b0;
    return s ^ iv[k];
  endfunction
  function automatic bit tap_at(input int u, input int dl);
    return (dl == 0) ? tr[u] : ((u - dl >= r) ? tr[u-dl] : 1'b0);
  endfunction
  task automatic tick();
    logic [HL-1:0] hv;
    bit pre_to, exp_to, exp_do;
    int dl;
    @(posedge clk);
    t++;
    dl = int'(io.delay);
    pre_to = tap_at(t - 1, dl);
    dv[t] = io.din;
    iv[t] = io.invert;
    if (reset) begin
      r = t; tr[t] = 1'b0; load_e = -1; n = 0;
    end else begin
      for (int i = 0; i < HL; i++) hv[i] = (t - 1 - i > r) ? hb0(t - 1 - i) : 1'b0;
      tr[t] = ((hv ^ io.trig_pattern) & io.mask) == '0;
      if (pre_to) begin
        load_e = t;
        lw = (io.stretch == '0) ? 64'd1 : io.stretch;
      end
      if (io.cnt_clear) n = 0;
      else if (pre_to) n++;
    end
    exp_do = (load_e >= 0) && (longint'(t - load_e) < longint'(lw));
    exp_to = tap_at(t, dl);
    #1;
    chk("trig_out", io.trig_out, exp_to);
    chk("dout", io.dout, exp_do);
    chk("trig_count", io.trig_count, (n > CMAX) ? CMAX : n);
    if (dv[t] && mark < 0) mark = t;
    if (io.trig_out) begin to_cnt++; if (first_to < 0) first_to = t; end
    if (io.dout) begin do_cnt++; last_do = t; if (first_do < 0) first_do = t; end
  endtask
  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask
  task automatic clr_meas();
    mark = -1; first_to = -1; first_do = -1; last_do = -1; to_cnt = 0; do_cnt = 0;
  endtask
  task automatic set_def();
    io.trig_pattern = 8'h01; io.mask = 8'h03; io.invert = 1'b0;
    io.delay = '0; io.stretch = 64'd1; io.cnt_clear = 1'b0;
  endtask
  task automatic rst_dut();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(12);
  endtask
  initial begin
    set_def();
    io.din = 1'b0;
    reset = 1'b1;
    clr_meas();
    tick();
    chk("reset_trig_out", io.trig_out, 1'b0);
    chk("reset_dout", io.dout, 1'b0);
    chk("reset_count", io.trig_count, '0);
    reset = 1'b0;
    run(12);
    // defaults: one-cycle rising-edge detect
    clr_meas();
    io.din = 1'b1;
    run(20);
    chk("def_to_lat", first_to - mark, 3);
    chk("def_do_lat", first_do - mark, 4);
    chk("def_do_width", do_cnt, 1);
    chk("def_to_pulses", to_cnt, 1);
    chk("def_count", io.trig_count, 1);
    // delay and stretch
    io.din = 1'b0;
    rst_dut();
    io.delay = 8'd10; io.stretch = 64'd5;
    clr_meas();
    io.din = 1'b1;
    run(20);
    chk("dly_to_lat", first_to - mark, 13);
    chk("dly_do_lat", first_do - mark, 14);
    chk("dly_do_width", do_cnt, 5);
    io.din = 1'b0;
    run(5);
    io.stretch = '0;
    clr_meas();
    io.din = 1'b1;
    run(20);
    chk("stretch0_width", do_cnt, 1);
    // inversion: falling edge triggers, rising does not
    set_def();
    io.invert = 1'b1;
    rst_dut();
    io.cnt_clear = 1'b1;
    tick();
    io.cnt_clear = 1'b0;
    clr_meas();
    io.din = 1'b0;
    run(15);
    chk("inv_fall_pulses", to_cnt, 1);
    chk("inv_fall_count", io.trig_count, 1);
    clr_meas();
    io.din = 1'b1;
    run(15);
    chk("inv_rise_pulses", to_cnt, 0);
    // retrigger reloads the stretch counter
    set_def();
    io.din = 1'b0;
    rst_dut();
    io.stretch = 64'd100;
    clr_meas();
    io.din = 1'b1; run(15);
    io.din = 1'b0; run(15);
    io.din = 1'b1; run(150);
    chk("retrig_do_lat", first_do - mark, 4);
    chk("retrig_width", do_cnt, 130);
    chk("retrig_span", last_do - first_do, 129);
    chk("retrig_count", io.trig_count, 2);
    // full-width pattern: four ones after four zeros
    set_def();
    io.din = 1'b0;
    rst_dut();
    io.trig_pattern = 8'h0F; io.mask = 8'hFF;
    clr_meas();
    io.din = 1'b1; run(3);
    io.din = 1'b0; run(12);
    chk("pat_short_pulses", to_cnt, 0);
    clr_meas();
    io.din = 1'b1; run(6);
    io.din = 1'b0; run(12);
    chk("pat_long_pulses", to_cnt, 1);
    // mask=0: continuous trigger, saturation and clear priority
    io.mask = '0;
    run(3);
    io.cnt_clear = 1'b1;
    tick();
    chk("clr_coinc_to", io.trig_out, 1'b1);
    chk("clr_coinc_count", io.trig_count, 0);
    io.cnt_clear = 1'b0;
    clr_meas();
    run(10);
    chk("mask0_pulses", to_cnt, 10);
    chk("mask0_count", io.trig_count, 10);
    run(10);
    chk("sat_count", io.trig_count, CMAX);
    io.cnt_clear = 1'b1;
    tick();
    chk("clr_sat_count", io.trig_count, 0);
    io.cnt_clear = 1'b0;
    // reset while stretching with a delayed trigger pending
    set_def();
    io.din = 1'b0;
    rst_dut();
    io.delay = 8'd20; io.stretch = 64'd50;
    clr_meas();
    io.din = 1'b1; run(10);
    io.din = 1'b0; run(20);
    io.din = 1'b1; run(10);
    chk("mid_dout_high", io.dout, 1'b1);
    io.din = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_dout", io.dout, 1'b0);
    clr_meas();
    run(100);
    chk("mid_no_to", to_cnt, 0);
    chk("mid_no_do", do_cnt, 0);
    // random traffic with random reconfiguration
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) io.din = ~io.din;
      if ($urandom_range(0, 199) == 0) begin
        io.trig_pattern = 8'($urandom);
        io.mask = ($urandom_range(0, 2) == 0) ? 8'h03 : 8'($urandom);
        if (io.mask == 8'h03) io.trig_pattern = 8'h01;
        io.delay = ($urandom_range(0, 5) == 0) ? 8'd255 : 8'($urandom_range(0, 40));
        io.stretch = 64'($urandom_range(0, 20));
        io.invert = 1'($urandom_range(0, 1));
      end
      io.cnt_clear = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    io.cnt_clear = 1'b0;
    run(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
